// File: rtl/oled_pkg.sv
// Shared opcode constants and command-decoder state encoding for the OLED
// panel command set, used by both the receiver and the panel driver.
package oled_pkg;

  typedef enum logic [1:0] {
    DEC_CMD  = 2'd0,
    DEC_ARG1 = 2'd1,
    DEC_ARG2 = 2'd2
  } dec_state_e;

  localparam logic [7:0] OP_DISPLAY_OFF = 8'hAE;
  localparam logic [7:0] OP_DISPLAY_ON  = 8'hAF;
  localparam logic [7:0] OP_ENTIRE_OFF  = 8'hA4;
  localparam logic [7:0] OP_ENTIRE_ON   = 8'hA5;
  localparam logic [7:0] OP_SEG_REMAP0  = 8'hA0;
  localparam logic [7:0] OP_SEG_REMAP1  = 8'hA1;
  localparam logic [7:0] OP_COM_SCAN0   = 8'hC0;
  localparam logic [7:0] OP_COM_SCAN1   = 8'hC8;
  localparam logic [7:0] OP_CONTRAST    = 8'h81;
  localparam logic [7:0] OP_CHARGE_PUMP = 8'h8D;
  localparam logic [7:0] OP_PRECHARGE   = 8'hD9;
  localparam logic [7:0] OP_COM_PINS    = 8'hDA;
  localparam logic [7:0] OP_COL_RANGE   = 8'h21;
  localparam logic [7:0] OP_PAGE_RANGE  = 8'h22;

  localparam logic [7:0] CONTRAST_RESET = 8'h7F;

  // Opcodes that are followed by at least one argument byte.
  function automatic logic takes_arg(input logic [7:0] op);
    return (op == OP_CONTRAST) || (op == OP_CHARGE_PUMP) ||
           (op == OP_PRECHARGE) || (op == OP_COM_PINS) ||
           (op == OP_COL_RANGE) || (op == OP_PAGE_RANGE);
  endfunction

endpackage

// File: rtl/spi_byte_rx.sv
// SPI byte framer: synchronizes the panel SPI lines, detects rising clock
// edges and assembles MSB-first bytes, flagging each completed byte.
module spi_byte_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       spi_clk,
  input  logic       spi_data,
  input  logic       spi_dc_n,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_is_data
);

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  logic [SYNC_STAGES-1:0] dc_sync_q, dc_sync_d;
  logic                   clk_prev_q, clk_prev_d;
  logic [7:0]             shift_q, shift_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic                   valid_q, valid_d;
  logic [7:0]             data_q, data_d;
  logic                   is_data_q, is_data_d;
  logic                   rise;
  logic                   sdata;

  always_comb begin
    clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], spi_clk};
    data_sync_d = {data_sync_q[SYNC_STAGES-2:0], spi_data};
    dc_sync_d   = {dc_sync_q[SYNC_STAGES-2:0], spi_dc_n};
    clk_prev_d  = clk_sync_q[SYNC_STAGES-1];
    rise        = clk_sync_q[SYNC_STAGES-1] & ~clk_prev_q;
    sdata       = data_sync_q[SYNC_STAGES-1];

    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    valid_d   = 1'b0;
    data_d    = data_q;
    is_data_d = is_data_q;

    // Panel reset / supply-off drops any partially framed byte.
    if (clear) begin
      shift_d   = 8'h00;
      bit_cnt_d = 3'd0;
    end else if (rise) begin
      shift_d   = {shift_q[6:0], sdata};
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        valid_d   = 1'b1;
        data_d    = {shift_q[6:0], sdata};
        is_data_d = dc_sync_q[SYNC_STAGES-1];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      clk_sync_q  <= '0;
      data_sync_q <= '0;
      dc_sync_q   <= '0;
      clk_prev_q  <= 1'b0;
      shift_q     <= 8'h00;
      bit_cnt_q   <= 3'd0;
      valid_q     <= 1'b0;
      data_q      <= 8'h00;
      is_data_q   <= 1'b0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      dc_sync_q   <= dc_sync_d;
      clk_prev_q  <= clk_prev_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      is_data_q   <= is_data_d;
    end
  end

  assign byte_valid   = valid_q;
  assign byte_data    = data_q;
  assign byte_is_data = is_data_q;

endmodule

// File: rtl/oled_spi_receiver.sv
// OLED SPI receiver: frames bytes from the panel SPI bus, decodes commands
// into panel state and turns data bytes into frame-buffer writes.
module oled_spi_receiver
  import oled_pkg::*;
#(
  parameter int COLS        = 128,
  parameter int PAGES       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       oled_spi_clk,
  input  logic       oled_spi_data,
  input  logic       oled_dc_n,
  input  logic       oled_reset_n,
  input  logic       oled_vdd,
  input  logic       oled_vbat,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_is_data,
  output logic       fb_we,
  output logic [8:0] fb_addr,
  output logic [7:0] fb_wdata,
  output logic       display_on,
  output logic       entire_on,
  output logic       charge_pump_on,
  output logic [7:0] contrast,
  output logic       cmd_error,
  output dec_state_e dbg_state
);

  localparam int CW = $clog2(COLS);
  localparam int PW = $clog2(PAGES);

  logic       rx_valid, rx_is_data;
  logic [7:0] rx_data;

  logic [SYNC_STAGES-1:0] rstn_sync_q, rstn_sync_d;
  logic [SYNC_STAGES-1:0] vdd_sync_q, vdd_sync_d;
  logic [SYNC_STAGES-1:0] vbat_sync_q, vbat_sync_d;
  logic                   panel_hold;

  dec_state_e    state_q, state_d;
  logic [7:0]    op_q, op_d;
  logic [CW-1:0] column_q, column_d, col_start_q, col_start_d, col_end_q, col_end_d;
  logic [PW-1:0] page_q, page_d, page_start_q, page_start_d, page_end_q, page_end_d;
  logic          display_on_q, display_on_d, entire_on_q, entire_on_d;
  logic          charge_pump_q, charge_pump_d;
  logic [7:0]    contrast_q, contrast_d;
  logic          byte_valid_q, byte_valid_d, byte_is_data_q, byte_is_data_d;
  logic [7:0]    byte_data_q, byte_data_d;
  logic          fb_we_q, fb_we_d, cmd_error_q, cmd_error_d;
  logic [8:0]    fb_addr_q, fb_addr_d;
  logic [7:0]    fb_wdata_q, fb_wdata_d;
  logic [CW-1:0] arg_col;
  logic [PW-1:0] arg_page;

  spi_byte_rx #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
    .clock        (clock),
    .reset        (reset),
    .clear        (panel_hold),
    .spi_clk      (oled_spi_clk),
    .spi_data     (oled_spi_data),
    .spi_dc_n     (oled_dc_n),
    .byte_valid   (rx_valid),
    .byte_data    (rx_data),
    .byte_is_data (rx_is_data)
  );

  always_comb begin
    rstn_sync_d = {rstn_sync_q[SYNC_STAGES-2:0], oled_reset_n};
    vdd_sync_d  = {vdd_sync_q[SYNC_STAGES-2:0], oled_vdd};
    vbat_sync_d = {vbat_sync_q[SYNC_STAGES-2:0], oled_vbat};
    panel_hold  = ~rstn_sync_q[SYNC_STAGES-1] | vdd_sync_q[SYNC_STAGES-1];
    arg_col     = CW'(rx_data);
    arg_page    = PW'(rx_data);

    state_d        = state_q;
    op_d           = op_q;
    column_d       = column_q;
    col_start_d    = col_start_q;
    col_end_d      = col_end_q;
    page_d         = page_q;
    page_start_d   = page_start_q;
    page_end_d     = page_end_q;
    display_on_d   = display_on_q;
    entire_on_d    = entire_on_q;
    charge_pump_d  = charge_pump_q;
    contrast_d     = contrast_q;
    byte_valid_d   = rx_valid;
    byte_data_d    = rx_data;
    byte_is_data_d = rx_is_data;
    fb_we_d        = 1'b0;
    fb_addr_d      = fb_addr_q;
    fb_wdata_d     = fb_wdata_q;
    cmd_error_d    = 1'b0;

    if (panel_hold) begin
      state_d       = DEC_CMD;
      column_d      = '0;
      col_start_d   = '0;
      col_end_d     = CW'(COLS - 1);
      page_d        = '0;
      page_start_d  = '0;
      page_end_d    = PW'(PAGES - 1);
      display_on_d  = 1'b0;
      entire_on_d   = 1'b0;
      charge_pump_d = 1'b0;
      contrast_d    = CONTRAST_RESET;
      byte_valid_d  = 1'b0;
    end else if (rx_valid && rx_is_data) begin
      // Data bytes go straight to the frame buffer; decoder state untouched.
      fb_we_d    = 1'b1;
      fb_addr_d  = 9'(page_q) * 9'(COLS) + 9'(column_q);
      fb_wdata_d = rx_data;
      if (column_q == col_end_q) begin
        column_d = col_start_q;
        page_d   = (page_q == page_end_q) ? page_start_q : page_q + PW'(1);
      end else begin
        column_d = column_q + CW'(1);
      end
    end else if (rx_valid) begin
      unique case (state_q)
        DEC_CMD: begin
          op_d = rx_data;
          if (rx_data[7:4] == 4'h0) begin
            column_d = CW'({column_q[CW-1:4], rx_data[3:0]});
          end else if (rx_data[7:4] == 4'h1) begin
            column_d = CW'({rx_data[3:0], column_q[3:0]});
          end else if (rx_data[7:3] == 5'b10110) begin
            page_d = PW'(rx_data[2:0]);
          end else if (takes_arg(rx_data)) begin
            state_d = DEC_ARG1;
          end else begin
            case (rx_data)
              OP_DISPLAY_OFF: display_on_d = 1'b0;
              OP_DISPLAY_ON:  display_on_d = 1'b1;
              OP_ENTIRE_OFF:  entire_on_d  = 1'b0;
              OP_ENTIRE_ON:   entire_on_d  = 1'b1;
              OP_SEG_REMAP0, OP_SEG_REMAP1, OP_COM_SCAN0, OP_COM_SCAN1: ;
              default:        cmd_error_d  = 1'b1;
            endcase
          end
        end
        DEC_ARG1: begin
          state_d = DEC_CMD;
          case (op_q)
            OP_CONTRAST:    contrast_d    = rx_data;
            OP_CHARGE_PUMP: charge_pump_d = rx_data[2];
            OP_COL_RANGE: begin
              col_start_d = arg_col;
              column_d    = arg_col;
              state_d     = DEC_ARG2;
            end
            OP_PAGE_RANGE: begin
              page_start_d = arg_page;
              page_d       = arg_page;
              state_d      = DEC_ARG2;
            end
            default: ;
          endcase
        end
        DEC_ARG2: begin
          // An end below the start collapses the window to the start.
          state_d = DEC_CMD;
          if (op_q == OP_COL_RANGE) begin
            col_end_d = (arg_col < col_start_q) ? col_start_q : arg_col;
          end else begin
            page_end_d = (arg_page < page_start_q) ? page_start_q : arg_page;
          end
        end
        default: state_d = DEC_CMD;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rstn_sync_q    <= '0;
      vdd_sync_q     <= '0;
      vbat_sync_q    <= '0;
      state_q        <= DEC_CMD;
      op_q           <= 8'h00;
      column_q       <= '0;
      col_start_q    <= '0;
      col_end_q      <= CW'(COLS - 1);
      page_q         <= '0;
      page_start_q   <= '0;
      page_end_q     <= PW'(PAGES - 1);
      display_on_q   <= 1'b0;
      entire_on_q    <= 1'b0;
      charge_pump_q  <= 1'b0;
      contrast_q     <= CONTRAST_RESET;
      byte_valid_q   <= 1'b0;
      byte_data_q    <= 8'h00;
      byte_is_data_q <= 1'b0;
      fb_we_q        <= 1'b0;
      fb_addr_q      <= 9'd0;
      fb_wdata_q     <= 8'h00;
      cmd_error_q    <= 1'b0;
    end else begin
      rstn_sync_q    <= rstn_sync_d;
      vdd_sync_q     <= vdd_sync_d;
      vbat_sync_q    <= vbat_sync_d;
      state_q        <= state_d;
      op_q           <= op_d;
      column_q       <= column_d;
      col_start_q    <= col_start_d;
      col_end_q      <= col_end_d;
      page_q         <= page_d;
      page_start_q   <= page_start_d;
      page_end_q     <= page_end_d;
      display_on_q   <= display_on_d;
      entire_on_q    <= entire_on_d;
      charge_pump_q  <= charge_pump_d;
      contrast_q     <= contrast_d;
      byte_valid_q   <= byte_valid_d;
      byte_data_q    <= byte_data_d;
      byte_is_data_q <= byte_is_data_d;
      fb_we_q        <= fb_we_d;
      fb_addr_q      <= fb_addr_d;
      fb_wdata_q     <= fb_wdata_d;
      cmd_error_q    <= cmd_error_d;
    end
  end

  assign byte_valid     = byte_valid_q;
  assign byte_data      = byte_data_q;
  assign byte_is_data   = byte_is_data_q;
  assign fb_we          = fb_we_q;
  assign fb_addr        = fb_addr_q;
  assign fb_wdata       = fb_wdata_q;
  assign display_on     = display_on_q & ~vbat_sync_q[SYNC_STAGES-1];
  assign entire_on      = entire_on_q;
  assign charge_pump_on = charge_pump_q;
  assign contrast       = contrast_q;
  assign cmd_error      = cmd_error_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_oled_spi_receiver.sv
// Bench for oled_spi_receiver: bit-bangs SPI bytes, queues the expected byte
// and frame-buffer responses, and a monitor checks them as the DUT emits them.
module tb_oled_spi_receiver;
  import oled_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       oled_spi_clk = 1'b0, oled_spi_data = 1'b0, oled_dc_n = 1'b0;
  logic       oled_reset_n = 1'b1, oled_vdd = 1'b0, oled_vbat = 1'b0;
  logic       byte_valid, byte_is_data, fb_we, cmd_error;
  logic [7:0] byte_data, fb_wdata, contrast;
  logic [8:0] fb_addr;
  logic       display_on, entire_on, charge_pump_on;
  dec_state_e dbg_state;

  // {cmd_error, fb_we, byte_is_data, byte_data} per byte; {fb_addr, fb_wdata} per write
  logic [10:0] exp_q[$];
  logic [16:0] fb_q[$];
  int tests = 0;
  int fails = 0;

  oled_spi_receiver dut (
    .clock(clock), .reset(reset),
    .oled_spi_clk(oled_spi_clk), .oled_spi_data(oled_spi_data), .oled_dc_n(oled_dc_n),
    .oled_reset_n(oled_reset_n), .oled_vdd(oled_vdd), .oled_vbat(oled_vbat),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_is_data(byte_is_data),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata),
    .display_on(display_on), .entire_on(entire_on), .charge_pump_on(charge_pump_on),
    .contrast(contrast), .cmd_error(cmd_error), .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    oled_spi_clk = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(6);
  endtask

  task automatic send_bit(input logic b, input logic dc);
    oled_spi_clk  = 1'b0;
    oled_spi_data = b;
    oled_dc_n     = dc;
    tick(4);
    oled_spi_clk = 1'b1;
    tick(4);
  endtask

  task automatic shift_byte(input logic [7:0] b, input logic dc);
    for (int i = 7; i >= 0; i--) send_bit(b[i], dc);
    oled_spi_clk = 1'b0;
    tick(4);
  endtask

  task automatic send_cmd(input logic [7:0] b, input logic err);
    exp_q.push_back({err, 1'b0, 1'b0, b});
    shift_byte(b, 1'b0);
  endtask

  task automatic send_data(input logic [7:0] b, input logic [8:0] addr);
    exp_q.push_back({1'b0, 1'b1, 1'b1, b});
    fb_q.push_back({addr, b});
    shift_byte(b, 1'b1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || fb_q.size() != 0) && n < 200) begin
      tick(1);
      n++;
    end
    check("drain_pending", exp_q.size() + fb_q.size(), 0);
    tick(4);
  endtask

  always @(negedge clock) begin
    logic [10:0] e;
    logic [16:0] f;
    if (byte_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_byte", {21'd0, cmd_error, fb_we, byte_is_data, byte_data}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("byte", {21'd0, cmd_error, fb_we, byte_is_data, byte_data}, {21'd0, e});
      end
      if (fb_we) begin
        if (fb_q.size() == 0) begin
          check("unexpected_write", {15'd0, fb_addr, fb_wdata}, 32'hFFFF_FFFF);
        end else begin
          f = fb_q.pop_front();
          check("fb_write", {15'd0, fb_addr, fb_wdata}, {15'd0, f});
        end
      end
    end else if (fb_we || cmd_error) begin
      check("strobe_without_valid", {30'd0, fb_we, cmd_error}, 32'd0);
    end
  end

  initial begin
    do_reset();
    check("rst_display_on", display_on, 0);
    check("rst_entire_on", entire_on, 0);
    check("rst_charge_pump", charge_pump_on, 0);
    check("rst_contrast", contrast, 32'h7F);
    check("rst_byte_valid", byte_valid, 0);
    check("rst_fb_we", fb_we, 0);
    check("rst_state", dbg_state, DEC_CMD);

    // Init sequence with argument opcodes.
    send_cmd(8'hAE, 0); send_cmd(8'h8D, 0); send_cmd(8'h14, 0); send_cmd(8'hD9, 0);
    send_cmd(8'hF1, 0); send_cmd(8'h81, 0); send_cmd(8'hFF, 0); send_cmd(8'hAF, 0);
    drain();
    check("init_charge_pump", charge_pump_on, 1);
    check("init_contrast", contrast, 32'hFF);
    check("init_display_on", display_on, 1);
    check("init_state", dbg_state, DEC_CMD);

    // Vbat off masks display_on without losing it.
    oled_vbat = 1'b1; tick(10);
    check("vbat_off_display", display_on, 0);
    oled_vbat = 1'b0; tick(10);
    check("vbat_on_display", display_on, 1);

    // Unknown opcode, then no-effect opcodes and normal decode.
    send_cmd(8'h3C, 1); send_cmd(8'hA1, 0); send_cmd(8'hC8, 0); send_cmd(8'hAE, 0);
    drain();
    check("after_err_display_off", display_on, 0);
    check("after_err_state", dbg_state, DEC_CMD);
    send_cmd(8'hAF, 0);
    drain();
    check("after_err_display_on", display_on, 1);

    // Horizontal addressing across full page 0 into page 1.
    do_reset();
    send_cmd(8'h22, 0); send_cmd(8'h00, 0); send_cmd(8'h03, 0); send_cmd(8'h10, 0);
    for (int i = 0; i < 128; i++) send_data(8'h55, 9'(i));
    send_data(8'hAA, 9'd128);
    drain();

    // Single-page window on page 3 wraps back to its column 0.
    do_reset();
    send_cmd(8'h22, 0); send_cmd(8'h03, 0); send_cmd(8'h03, 0);
    for (int i = 0; i < 128; i++) send_data(8'(i), 9'(384 + i));
    send_data(8'hC3, 9'd384);
    drain();

    // Page/column nibble commands, inverted column range, page wrap.
    do_reset();
    send_cmd(8'hB2, 0); send_cmd(8'h05, 0); send_cmd(8'h13, 0);
    send_data(8'h11, 9'd309);
    send_cmd(8'h21, 0); send_cmd(8'h10, 0); send_cmd(8'h05, 0);
    send_data(8'h22, 9'd272);
    send_data(8'h33, 9'd400);
    send_data(8'h44, 9'd16);
    drain();

    // Panel reset after 5 bits: partial byte dropped, state back to defaults.
    do_reset();
    send_cmd(8'h81, 0); send_cmd(8'h20, 0);
    drain();
    check("contrast_loaded", contrast, 32'h20);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    oled_spi_clk = 1'b0;
    oled_reset_n = 1'b0; tick(10);
    check("panel_rst_contrast", contrast, 32'h7F);
    oled_reset_n = 1'b1; tick(10);
    send_cmd(8'hA5, 0);
    drain();
    check("panel_rst_entire_on", entire_on, 1);

    // System reset mid-byte: partial bits discarded.
    for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b0);
    do_reset();
    check("mid_rst_entire_on", entire_on, 0);
    send_cmd(8'hAF, 0);
    drain();
    check("mid_rst_display_on", display_on, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/oled_spi_receiver.md
OLED_SPI_RECEIVER -- requirements
Module: oled_spi_receiver

Interface
REQ-001 Parameter COLS, default 128, number of display columns.
REQ-002 Parameter PAGES, default 4, number of 8-row pages.
REQ-003 Parameter SYNC_STAGES, default 2, synchronizer depth for SPI inputs.
REQ-004 clock  input  1  system clock (100 MHz).
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 oled_spi_clk  input  1  serial clock from panel driver; at most clock/8.
REQ-007 oled_spi_data  input  1  serial data, MSB first.
REQ-008 oled_dc_n  input  1  0 = command byte, 1 = GDDRAM data byte.
REQ-009 oled_reset_n  input  1  panel reset, active-low.
REQ-010 oled_vdd / oled_vbat  input  1 each  logic / panel supply enables, active-low.
REQ-011 byte_valid  output  1  one-cycle pulse per received byte.
REQ-012 byte_data  output  8  received byte; byte_is_data output 1: sampled dc_n.
REQ-013 fb_we  output  1  frame-buffer write strobe; fb_addr output 9: page*COLS+column; fb_wdata output 8.
REQ-014 display_on, entire_on, charge_pump_on  output  1 each  decoded panel state.
REQ-015 contrast  output  8  last contrast argument; cmd_error output 1: one-cycle pulse on unknown opcode.

Function
REQ-016 oled_spi_clk, oled_spi_data, oled_dc_n SHALL pass through SYNC_STAGES flops; rising edge = synced clk 0->1.
REQ-017 On each detected rising edge the receiver SHALL shift synced data into an 8-bit register, MSB first, and increment a 3-bit bit counter.
REQ-018 On the 8th edge, byte_valid, byte_data, byte_is_data SHALL be driven in the next clock, dc_n sampled at the 8th edge.
REQ-019 oled_reset_n low or oled_vdd high SHALL clear bit counter, decoder state, pointers and panel state to reset values, holding them while asserted.
REQ-020 Decoder states: CMD, ARG1, ARG2; data bytes bypass the decoder and never change its state.
REQ-021 CMD opcodes: AE/AF set display_on 0/1; A4/A5 set entire_on 0/1; 00-0F set column low nibble; 10-1F set column high nibble; B0-B7 set page pointer; A0/A1, C0/C8 accepted, no effect.
REQ-022 CMD opcodes 81, 8D, D9, DA -> ARG1; argument consumed, return CMD; 81 loads contrast; 8D loads charge_pump_on = arg bit 2.
REQ-023 Opcodes 21 (column range) and 22 (page range) -> ARG1 (start, also loads pointer) -> ARG2 (end) -> CMD.
REQ-024 Any other command byte SHALL pulse cmd_error and stay in CMD.
REQ-025 Data byte SHALL assert fb_we with byte_valid, fb_addr = page*COLS+column, fb_wdata = byte.
REQ-026 After a data write: column == col_end -> column = col_start and page advances; page == page_end -> page = page_start; otherwise column+1 (horizontal addressing).
REQ-027 Range arguments SHALL be truncated to log2(COLS)/log2(PAGES) bits; start > end SHALL behave as start == end.
REQ-028 oled_vbat high SHALL force display_on output low without altering the stored value.

Reset
REQ-029 reset SHALL clear all outputs and counters: display_on 0, entire_on 0, charge_pump_on 0, contrast 7F, column/page 0, col_end COLS-1, page_end PAGES-1, state CMD.
REQ-030 reset mid-byte SHALL discard partial bits; first byte after release is framed from bit 7.

Structure
REQ-031 Opcode constants and decoder state encodings SHALL live in shared package oled_pkg, reused by the panel driver.
REQ-032 One sub-module, spi_byte_rx (sync, edge detect, shift, bit count), SHALL feed the decoder FSM.

Verification
REQ-033 Send AE,8D,14,D9,F1,81,FF,AF (dc_n=0) -> eight byte_valid pulses, charge_pump_on=1, contrast=FF, display_on=1, no cmd_error.
REQ-034 Send 22,00,03,10 then 128 data bytes 55 -> fb_we x128, fb_addr 0..127, then next data byte at fb_addr 128.
REQ-035 Send 22,03,03 then 129 data bytes -> last write at fb_addr 384 (page 3 wrap to column 0).
REQ-036 Send opcode 3C -> cmd_error pulse one cycle; following AF decoded normally.
REQ-037 Pulse oled_reset_n low after 5 bits, then send A5 -> partial bits discarded, entire_on=1.
REQ-038 Hold oled_vbat=1 after AF -> display_on=0; release -> display_on=1.
